// File: rtl/i2c_pkg.sv
// Shared definitions for the segment-controller I2C initiator and its target.
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      BIT   = 3'd2,
      ACK   = 3'd3,
      STOP  = 3'd4
   } i2c_state_t;

   localparam logic       I2C_RW_WRITE = 1'b0;
   localparam logic [6:0] SEG_I2C_ADDR = 7'h3C;

   // Open-drain drive for a data bit: a 0 is pulled low, a 1 is released.
   function automatic logic sda_oe_for_bit(input logic b);
      return ~b;
   endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// SCL quarter-period timebase: clk divider plus 2-bit quarter index.
module i2c_quarter_tick
   import i2c_pkg::*;
#(
   parameter int unsigned CLK_DIV = 25
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr_i,
   input  logic       en_i,
   output logic       tick_o,
   output logic [1:0] q_o
);

   localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       q_q;

   assign tick_o = en_i && (cnt_q == CNT_LAST);
   assign q_o    = q_q;

   // Divider wraps every CLK_DIV cycles; the quarter index advances on wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         q_q   <= 2'd0;
      end else if (clr_i) begin
         cnt_q <= '0;
         q_q   <= 2'd0;
      end else if (en_i) begin
         if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            q_q   <= q_q + 2'd1;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_q <= cnt_q;
         q_q   <= q_q;
      end
   end

endmodule

// File: rtl/i2c_seg_writer.sv
// Single-byte I2C write initiator (START, addr+W, ACK, data, ACK, STOP).
// Line drives are decoded from the current state and registered, so every
// output trails the state register by one clk.
module i2c_seg_writer
   import i2c_pkg::*;
#(
   parameter int unsigned CLK_DIV = 25
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_i,
   input  logic [6:0] addr_i,
   input  logic [7:0] data_i,
   input  logic       sda_i,
   output logic       scl_oe_o,
   output logic       sda_oe_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       nack_o
);

   i2c_state_t state_q;
   logic [2:0] bit_cnt_q;
   logic       byte_sel_q;
   logic [7:0] shift_q;
   logic [7:0] data_q;
   logic       busy_q;
   logic       done_q;
   logic       nack_q;
   logic       scl_oe_q;
   logic       sda_oe_q;
   logic       scl_oe_d;
   logic       sda_oe_d;
   logic       accept_s;
   logic       run_s;
   logic       tick_s;
   logic       qend_s;
   logic [1:0] q_s;

   // A request in the done cycle is dropped because busy_q/done_q gate it.
   assign accept_s = (state_q == IDLE) && start_i && !busy_q && !done_q;
   assign run_s    = (state_q != IDLE);
   assign qend_s   = tick_s && (q_s == 2'd3);

   i2c_quarter_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (accept_s),
      .en_i   (run_s),
      .tick_o (tick_s),
      .q_o    (q_s)
   );

   // Line pattern for the current state and quarter.
   always_comb begin
      scl_oe_d = 1'b0;
      sda_oe_d = 1'b0;
      case (state_q)
         IDLE: begin
            scl_oe_d = 1'b0;
            sda_oe_d = 1'b0;
         end
         START: begin
            scl_oe_d = (q_s == 2'd3);
            sda_oe_d = q_s[1];
         end
         BIT: begin
            scl_oe_d = !q_s[1];
            sda_oe_d = sda_oe_for_bit(shift_q[7]);
         end
         ACK: begin
            scl_oe_d = !q_s[1];
            sda_oe_d = 1'b0;
         end
         STOP: begin
            scl_oe_d = !q_s[1];
            sda_oe_d = (q_s != 2'd3);
         end
         default: begin
            scl_oe_d = 1'b0;
            sda_oe_d = 1'b0;
         end
      endcase
   end

   // Transaction FSM with registered line drives and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bit_cnt_q  <= 3'd0;
         byte_sel_q <= 1'b0;
         shift_q    <= 8'h00;
         data_q     <= 8'h00;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         nack_q     <= 1'b0;
         scl_oe_q   <= 1'b0;
         sda_oe_q   <= 1'b0;
      end else begin
         scl_oe_q <= scl_oe_d;
         sda_oe_q <= sda_oe_d;
         done_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (busy_q) begin
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
               end else if (accept_s) begin
                  state_q    <= START;
                  shift_q    <= {addr_i, I2C_RW_WRITE};
                  data_q     <= data_i;
                  bit_cnt_q  <= 3'd0;
                  byte_sel_q <= 1'b0;
                  busy_q     <= 1'b1;
                  nack_q     <= 1'b0;
               end else begin
                  state_q <= IDLE;
               end
            end
            START: begin
               if (qend_s) begin
                  state_q   <= BIT;
                  bit_cnt_q <= 3'd0;
               end else begin
                  state_q <= START;
               end
            end
            BIT: begin
               if (qend_s) begin
                  shift_q <= {shift_q[6:0], 1'b0};
                  if (bit_cnt_q == 3'd7) begin
                     state_q   <= ACK;
                     bit_cnt_q <= 3'd0;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                  end
               end else begin
                  state_q <= BIT;
               end
            end
            ACK: begin
               // nack_q doubles as the ACK sample: 1 means the target let SDA float.
               if (tick_s && (q_s == 2'd2)) begin
                  nack_q <= sda_i;
               end else if (qend_s) begin
                  if (nack_q || byte_sel_q) begin
                     state_q <= STOP;
                  end else begin
                     state_q    <= BIT;
                     shift_q    <= data_q;
                     byte_sel_q <= 1'b1;
                     bit_cnt_q  <= 3'd0;
                  end
               end else begin
                  state_q <= ACK;
               end
            end
            STOP: begin
               if (qend_s) begin
                  state_q <= IDLE;
               end else begin
                  state_q <= STOP;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign scl_oe_o = scl_oe_q;
   assign sda_oe_o = sda_oe_q;
   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign nack_o   = nack_q;

endmodule

// File: tb/tb_i2c_seg_writer.sv
// Directed bench for i2c_seg_writer with an open-drain bus target model
// and a line-level protocol monitor.
module tb_i2c_seg_writer;

   localparam int D = 4;

   logic       clk;
   logic       rst_n;
   logic       start_i;
   logic [6:0] addr_i;
   logic [7:0] data_i;
   logic       sda_i;
   logic       scl_oe_o;
   logic       sda_oe_o;
   logic       busy_o;
   logic       done_o;
   logic       nack_o;

   logic       slv_pull;
   logic       scl_line;
   logic       sda_line;

   int checks   = 0;
   int failures = 0;

   // target model state
   logic       mdl_en;
   int         ack_mode;
   logic       m_prev_scl, m_prev_sda;
   int         sbit, nbyte, ncap, n_start, n_stop;
   logic [7:0] shreg;
   logic [7:0] cap [0:3];

   // monitor state
   logic       chk_en;
   logic       c_prev_scl, c_prev_sda;
   int         plen, ph_n, ph_bad, n_sda_hi;
   logic       seen_fall, seen_rise;

   // per-transaction observations
   int         done_cyc, n_done;
   logic       busy_at_done, busy_after_acc, nack_after_acc;

   assign scl_line = !scl_oe_o;
   assign sda_line = !(sda_oe_o || slv_pull);
   assign sda_i    = sda_line;

   i2c_seg_writer #(.CLK_DIV(D)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (start_i),
      .addr_i   (addr_i),
      .data_i   (data_i),
      .sda_i    (sda_i),
      .scl_oe_o (scl_oe_o),
      .sda_oe_o (sda_oe_o),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .nack_o   (nack_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Target: captures bytes on SCL rises, ACKs according to ack_mode
   // (0 never, 1 address only, 2 every byte).
   always @(negedge clk) begin
      m_prev_scl <= scl_line;
      m_prev_sda <= sda_line;
      if (!mdl_en) begin
         slv_pull <= 1'b0;
         sbit <= 0; nbyte <= 0; ncap <= 0; n_start <= 0; n_stop <= 0;
         shreg <= 8'h00;
      end else if (m_prev_scl && scl_line && m_prev_sda && !sda_line) begin
         n_start <= n_start + 1; sbit <= 0; nbyte <= 0; slv_pull <= 1'b0;
      end else if (m_prev_scl && scl_line && !m_prev_sda && sda_line) begin
         n_stop <= n_stop + 1; slv_pull <= 1'b0;
      end else if (!m_prev_scl && scl_line) begin
         if (sbit < 8) shreg <= {shreg[6:0], sda_line};
         sbit <= sbit + 1;
      end else if (m_prev_scl && !scl_line) begin
         if (sbit == 8) begin
            if (ncap < 4) cap[ncap] <= shreg;
            ncap     <= ncap + 1;
            slv_pull <= (ack_mode == 2) || (ack_mode == 1 && nbyte == 0);
         end else if (sbit == 9) begin
            slv_pull <= 1'b0; sbit <= 0; nbyte <= nbyte + 1;
         end
      end
   end

   // Monitor: SDA edges while SCL high, and SCL phase lengths.
   // First low phase after START spans 3 quarters; the idle high before START is unbounded.
   always @(negedge clk) begin
      c_prev_scl <= scl_line;
      c_prev_sda <= sda_line;
      if (!chk_en) begin
         plen <= 0; ph_n <= 0; ph_bad <= 0; n_sda_hi <= 0;
         seen_fall <= 1'b0; seen_rise <= 1'b0;
      end else begin
         if (c_prev_scl && scl_line && (c_prev_sda != sda_line)) n_sda_hi <= n_sda_hi + 1;
         if (c_prev_scl != scl_line) begin
            plen <= 1;
            if (!scl_line) begin
               if (seen_fall) begin
                  ph_n <= ph_n + 1;
                  if (plen != 2 * D) ph_bad <= ph_bad + 1;
               end
               seen_fall <= 1'b1;
            end else begin
               ph_n <= ph_n + 1;
               if (plen != (seen_rise ? 2 * D : 3 * D)) ph_bad <= ph_bad + 1;
               seen_rise <= 1'b1;
            end
         end else begin
            plen <= plen + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs one request and watches ncyc cycles after the sample edge; an extra
   // start pulse (addr 7F / data FF) is injected after edge inj_at when nonzero.
   task automatic do_txn(input logic [6:0] a, input logic [7:0] d, input int mode,
                         input int inj_at, input int ncyc);
      @(posedge clk); #1;
      mdl_en = 1'b0; chk_en = 1'b0; ack_mode = mode;
      @(posedge clk); #1;
      mdl_en = 1'b1; chk_en = 1'b1;
      start_i = 1'b1; addr_i = a; data_i = d;
      @(posedge clk); #1;
      start_i = 1'b0;
      busy_after_acc = busy_o;
      nack_after_acc = nack_o;
      done_cyc = -1; n_done = 0; busy_at_done = 1'bx;
      for (int n = 1; n <= ncyc; n++) begin
         @(posedge clk); #1;
         start_i = (n == inj_at);
         if (n == inj_at) begin
            addr_i = 7'h7F; data_i = 8'hFF;
         end
         if (done_o) begin
            n_done++;
            if (done_cyc < 0) begin
               done_cyc = n; busy_at_done = busy_o;
            end
         end
      end
      start_i = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start_i = 1'b0; addr_i = 7'h00; data_i = 8'h00;
      mdl_en = 1'b0; chk_en = 1'b0; ack_mode = 2;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_scl", {31'd0, scl_oe_o}, 32'd0);
      chk("rst_sda", {31'd0, sda_oe_o}, 32'd0);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_done", {31'd0, done_o}, 32'd0);
      chk("rst_nack", {31'd0, nack_o}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_busy", {31'd0, busy_o}, 32'd0);

      // ACKed write 0x3C / 0xA5
      do_txn(7'h3C, 8'hA5, 2, 0, 400);
      chk("t1_busy_acc", {31'd0, busy_after_acc}, 32'd1);
      chk("t1_done_cyc", done_cyc, 32'd321);
      chk("t1_n_done", n_done, 32'd1);
      chk("t1_busy_at_done", {31'd0, busy_at_done}, 32'd0);
      chk("t1_nack", {31'd0, nack_o}, 32'd0);
      chk("t1_ncap", ncap, 32'd2);
      chk("t1_byte0", {24'd0, cap[0]}, 32'h78);
      chk("t1_byte1", {24'd0, cap[1]}, 32'hA5);
      chk("t1_starts", n_start, 32'd1);
      chk("t1_stops", n_stop, 32'd1);
      chk("t1_sda_hi_edges", n_sda_hi, 32'd2);
      chk("t1_phase_bad", ph_bad, 32'd0);
      chk("t1_phase_n", ph_n, 32'd37);

      // address NACK, 0x11
      do_txn(7'h11, 8'h5A, 0, 0, 400);
      chk("t2_done_cyc", done_cyc, 32'd177);
      chk("t2_n_done", n_done, 32'd1);
      chk("t2_nack", {31'd0, nack_o}, 32'd1);
      chk("t2_ncap", ncap, 32'd1);
      chk("t2_byte0", {24'd0, cap[0]}, 32'h22);
      chk("t2_stops", n_stop, 32'd1);
      chk("t2_sda_hi_edges", n_sda_hi, 32'd2);
      chk("t2_phase_bad", ph_bad, 32'd0);
      chk("t2_phase_n", ph_n, 32'd19);

      // data NACK, data 0x00
      do_txn(7'h3C, 8'h00, 1, 0, 400);
      chk("t3_done_cyc", done_cyc, 32'd321);
      chk("t3_nack", {31'd0, nack_o}, 32'd1);
      chk("t3_ncap", ncap, 32'd2);
      chk("t3_byte1", {24'd0, cap[1]}, 32'h00);

      // new accept clears nack; start while busy is ignored
      do_txn(7'h3C, 8'h5A, 2, 50, 400);
      chk("t4_nack_clr", {31'd0, nack_after_acc}, 32'd0);
      chk("t4_done_cyc", done_cyc, 32'd321);
      chk("t4_n_done", n_done, 32'd1);
      chk("t4_byte0", {24'd0, cap[0]}, 32'h78);
      chk("t4_byte1", {24'd0, cap[1]}, 32'h5A);
      chk("t4_starts", n_start, 32'd1);
      chk("t4_nack", {31'd0, nack_o}, 32'd0);

      // start in the done cycle is ignored
      do_txn(7'h3C, 8'h3C, 2, 321, 400);
      chk("t5_n_done", n_done, 32'd1);
      chk("t5_busy_end", {31'd0, busy_o}, 32'd0);
      chk("t5_starts", n_start, 32'd1);

      // async reset during data bit 3 (data 0xC3, fourth bit is 0)
      do_txn(7'h3C, 8'hC3, 2, 0, 212);
      #3;
      chk("t6_pre_scl", {31'd0, scl_oe_o}, 32'd1);
      chk("t6_pre_sda", {31'd0, sda_oe_o}, 32'd1);
      chk("t6_pre_busy", {31'd0, busy_o}, 32'd1);
      chk_en = 1'b0; mdl_en = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_scl", {31'd0, scl_oe_o}, 32'd0);
      chk("t6_rst_sda", {31'd0, sda_oe_o}, 32'd0);
      chk("t6_rst_busy", {31'd0, busy_o}, 32'd0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      do_txn(7'h3C, 8'h96, 2, 0, 400);
      chk("t6_done_cyc", done_cyc, 32'd321);
      chk("t6_nack", {31'd0, nack_o}, 32'd0);
      chk("t6_byte0", {24'd0, cap[0]}, 32'h78);
      chk("t6_byte1", {24'd0, cap[1]}, 32'h96);
      chk("t6_phase_bad", ph_bad, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
